intc: RTL and testbench



---
 rtl/intc.sv | 107 ++++++++++
 tb/tb_intc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// Four-source fixed-priority interrupt controller: latches done strobes as pending
// requests and presents the highest-priority one to the CPU via an irq/iack handshake.
module intc #(
  parameter logic [31:0] VEC1 = 32'h0000_0100,
  parameter logic [31:0] VEC2 = 32'h0000_0200,
  parameter logic [31:0] VEC3 = 32'h0000_0300,
  parameter logic [31:0] VEC4 = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iack,
  input  logic        done1,
  input  logic        done2,
  input  logic        done3,
  input  logic        done4,
  output logic [31:0] PC_handler,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] pc_q, pc_d;
  logic        irq_q, irq_d;
  logic [1:0]  prio_idx;
  logic [31:0] prio_vec;

  // Bit 0 of pending is source 1 (highest priority).
  always_comb begin
    prio_idx = 2'd3;
    if (pending_q[0])      prio_idx = 2'd0;
    else if (pending_q[1]) prio_idx = 2'd1;
    else if (pending_q[2]) prio_idx = 2'd2;
  end

  always_comb begin
    case (prio_idx)
      2'd0:    prio_vec = VEC1;
      2'd1:    prio_vec = VEC2;
      2'd2:    prio_vec = VEC3;
      default: prio_vec = VEC4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    pc_d      = pc_q;
    irq_d     = irq_q;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (!iack && (|pending_q)) begin
          sel_d   = prio_idx;
          pc_d    = prio_vec;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        irq_d = 1'b1;
        if (iack) begin
          pending_d[sel_q] = 1'b0;
          irq_d            = 1'b0;
          state_d          = ACK;
        end
      end
      ACK: begin
        irq_d = 1'b0;
        if (!iack) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    // Applied after the ack clear so a strobe on the ack edge re-arms the source.
    pending_d = pending_d | {done4, done3, done2, done1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      pc_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      pc_q      <= pc_d;
      irq_q     <= irq_d;
    end
  end

  assign PC_handler = pc_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_intc.sv
// Scoreboard bench for intc: expected handler addresses are queued when done strobes
// are driven and popped when the controller raises irq.
module tb_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic        iack;
  logic [3:0]  done;
  logic [31:0] PC_handler;
  logic        irq;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] exp_q[$];

  intc #(
    .VEC1(32'h0000_0100),
    .VEC2(32'h0000_0200),
    .VEC3(32'h0000_0300),
    .VEC4(32'h0000_0400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iack      (iack),
    .done1     (done[0]),
    .done2     (done[1]),
    .done3     (done[2]),
    .done4     (done[3]),
    .PC_handler(PC_handler),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string name, input logic exp);
    nvec++;
    if (irq !== exp) begin
      nerr++;
      $display("FAIL %s: irq got %b expected %b", name, irq, exp);
    end
  endtask

  // Pops the next expected vector and compares it against the presented handler.
  task automatic pop_pc(input string name);
    logic [31:0] e;
    nvec++;
    if (exp_q.size() == 0) begin
      nerr++;
      $display("FAIL %s: PC_handler got %h with empty scoreboard", name, PC_handler);
    end else begin
      e = exp_q.pop_front();
      if (irq !== 1'b1 || PC_handler !== e) begin
        nerr++;
        $display("FAIL %s: irq/PC_handler got %b/%h expected 1/%h", name, irq, PC_handler, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iack = 1'b0; done = '0;
    repeat (2) tick();
    nvec++;
    if (irq !== 1'b0 || PC_handler !== 32'h0) begin
      nerr++;
      $display("FAIL reset_state: irq/PC got %b/%h expected 0/00000000", irq, PC_handler);
    end
    rst = 1'b0;
    repeat (3) tick();
    check_irq("reset_idle", 1'b0);
  endtask

  task automatic test_single();
    done = 4'b0100; exp_q.push_back(32'h300);
    tick();
    done = '0;
    check_irq("single_latency", 1'b0);
    tick();
    pop_pc("single_pc");
    iack = 1'b1;
    tick();
    check_irq("single_ack_drop", 1'b0);
    iack = 1'b0;
    repeat (3) tick();
    check_irq("single_stays_low", 1'b0);
    nvec++;
    if (PC_handler !== 32'h300) begin
      nerr++;
      $display("FAIL single_pc_hold: PC_handler got %h expected 00000300", PC_handler);
    end
  endtask

  task automatic test_all4();
    done = 4'b1111;
    exp_q.push_back(32'h100); exp_q.push_back(32'h200);
    exp_q.push_back(32'h300); exp_q.push_back(32'h400);
    tick();
    done = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      pop_pc("all4_pc");
      iack = 1'b1;
      tick();
      check_irq("all4_ack_drop", 1'b0);
      iack = 1'b0;
      tick();
      check_irq("all4_gap", 1'b0);
      tick();
      check_irq("all4_rerise", (k < 3) ? 1'b1 : 1'b0);
    end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    repeat (3) tick();
    check_irq("all4_extra_ack", 1'b0);
    nvec++;
    if (PC_handler !== 32'h400) begin
      nerr++;
      $display("FAIL all4_extra_pc: PC_handler got %h expected 00000400", PC_handler);
    end
  endtask

  task automatic test_long_iack();
    done = 4'b0011;
    exp_q.push_back(32'h100); exp_q.push_back(32'h200);
    tick();
    done = '0;
    tick();
    pop_pc("long_first");
    iack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_irq("long_hold", 1'b0);
    end
    iack = 1'b0;
    tick();
    check_irq("long_gap", 1'b0);
    tick();
    pop_pc("long_second");
    iack = 1'b1;
    tick();
    iack = 1'b0;
    repeat (3) tick();
    check_irq("long_drained", 1'b0);
  endtask

  task automatic test_no_preempt();
    done = 4'b1000; exp_q.push_back(32'h400);
    tick();
    done = '0;
    tick();
    pop_pc("nopre_src4");
    done = 4'b0001; exp_q.push_back(32'h100);
    tick();
    done = '0;
    tick();
    nvec++;
    if (irq !== 1'b1 || PC_handler !== 32'h400) begin
      nerr++;
      $display("FAIL nopre_hold: irq/PC got %b/%h expected 1/00000400", irq, PC_handler);
    end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
    tick();
    pop_pc("nopre_src1");
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
  endtask

  task automatic test_rearm();
    done = 4'b0010; exp_q.push_back(32'h200);
    tick();
    done = '0;
    tick();
    pop_pc("rearm_first");
    iack = 1'b1; done = 4'b0010; exp_q.push_back(32'h200);
    tick();
    done = '0;
    check_irq("rearm_ack_drop", 1'b0);
    iack = 1'b0;
    tick();
    tick();
    pop_pc("rearm_second");
    iack = 1'b1;
    tick();
    iack = 1'b0;
    repeat (3) tick();
    check_irq("rearm_drained", 1'b0);
  endtask

  task automatic test_iack_idle();
    iack = 1'b1; done = 4'b0001; exp_q.push_back(32'h100);
    tick();
    done = '0;
    repeat (3) tick();
    check_irq("iack_idle_wait", 1'b0);
    iack = 1'b0;
    tick();
    pop_pc("iack_idle_release");
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    done = 4'b0101; exp_q.push_back(32'h100);
    tick();
    done = '0;
    tick();
    pop_pc("rstmid_req");
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (irq !== 1'b0 || PC_handler !== 32'h0) begin
      nerr++;
      $display("FAIL rstmid_async: irq/PC got %b/%h expected 0/00000000", irq, PC_handler);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_irq("rstmid_pending_lost", 1'b0);
    end
    done = 4'b0010; exp_q.push_back(32'h200);
    tick();
    done = '0;
    tick();
    pop_pc("rstmid_new");
    iack = 1'b1;
    tick();
    iack = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all4();
    test_long_iack();
    test_no_preempt();
    test_rearm();
    test_iack_idle();
    test_reset_mid();
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_empty: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
